sdram_init_sequencer: RTL and testbench



---
 rtl/sdram_pkg.sv | 45 ++++
 rtl/sync_lock_filter.sv | 48 ++++
 rtl/sdram_init_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_sdram_init_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : sdram_pkg                                                     |
// | Purpose  : Shared SDRAM command encodings, init-sequencer state type and |
// |            default timing constants for the SDRAM power-up block.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] c_CMD_NOP       = 4'b0111;
    localparam logic [3:0] c_CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] c_CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] c_CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] c_CMD_INHIBIT   = 4'b1111;

    // A10 high on PRECHARGE selects all banks
    localparam logic [12:0] c_ADDR_ALL_BANKS = 13'h0400;

    // Default timing, in cycles of the 143 MHz SDRAM clock
    localparam int          c_LOCK_FILTER    = 16;
    localparam int          c_POWERUP_CYC    = 14300;
    localparam int          c_T_RP           = 3;
    localparam int          c_T_RFC          = 10;
    localparam int          c_T_MRD          = 2;
    localparam int          c_INIT_REFRESHES = 8;
    localparam int          c_REF_INTERVAL   = 1117;
    localparam logic [12:0] c_MODE_REG       = 13'h0030;

    typedef enum logic [3:0] {
        ST_LOCK_WAIT     = 4'd0,
        ST_POWERUP       = 4'd1,
        ST_PRECHARGE     = 4'd2,
        ST_PRE_WAIT      = 4'd3,
        ST_INIT_REF      = 4'd4,
        ST_INIT_REF_WAIT = 4'd5,
        ST_LOAD_MODE     = 4'd6,
        ST_MRD_WAIT      = 4'd7,
        ST_IDLE          = 4'd8,
        ST_AUTO_REF      = 4'd9,
        ST_AUTO_WAIT     = 4'd10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_lock_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sync_lock_filter                                              |
// | Purpose  : Two-flop synchronizer for the asynchronous PLL lock flag      |
// |            followed by a saturating run-length filter.                   |
// | Ports    : clk, rst_n (sync, active-low), i_pll_locked (async),          |
// |            o_lock_ok (high after LOCK_FILTER consecutive high samples).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sync_lock_filter #(
    parameter int LOCK_FILTER = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pll_locked,
    output logic o_lock_ok
);

    localparam int c_CNT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_SAT = c_CNT_W'(LOCK_FILTER - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pll_locked;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // The current synchronized sample counts as the last of the run, so a
    // single low sample drops lock_ok immediately and a full run of
    // LOCK_FILTER highs raises it without an extra register stage.
    assign o_lock_ok = r_sync2 && (r_cnt == c_CNT_SAT);

endmodule
`default_nettype wire

// File: rtl/sdram_init_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sdram_init_sequencer                                          |
// | Purpose  : SDRAM power-up sequence (NOP wait, precharge-all, N refresh,  |
// |            load mode) after PLL lock, then periodic refresh requests.    |
// | Ports    : clk, rst_n (sync, active-low), pll_locked (async)             |
// |            cmd[3:0] {cs_n,ras_n,cas_n,we_n}, addr[12:0], ba[1:0], cke    |
// |            cmd_own (block drives the command bus), init_done             |
// |            ref_req / ref_ack (arbiter handshake), ref_late (overrun)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sdram_init_sequencer
    import sdram_pkg::*;
#(
    parameter int          LOCK_FILTER    = c_LOCK_FILTER,
    parameter int          POWERUP_CYC    = c_POWERUP_CYC,
    parameter int          T_RP           = c_T_RP,      // >= 2
    parameter int          T_RFC          = c_T_RFC,     // >= 2
    parameter int          T_MRD          = c_T_MRD,     // >= 2
    parameter int          INIT_REFRESHES = c_INIT_REFRESHES,
    parameter int          REF_INTERVAL   = c_REF_INTERVAL,
    parameter logic [12:0] MODE_REG       = c_MODE_REG
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_locked,
    output logic [3:0]  cmd,
    output logic [12:0] addr,
    output logic [1:0]  ba,
    output logic        cke,
    output logic        cmd_own,
    output logic        init_done,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        ref_late
);

    // One shared wait counter; POWERUP_CYC is the longest wait by far.
    localparam int c_WAIT_W = $clog2(POWERUP_CYC + 1);
    localparam int c_TMR_W  = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int c_RCNT_W = $clog2(INIT_REFRESHES + 1);

    // Wait states last (T - 1) cycles, so the counter is loaded with T - 2
    // and the state is left on the cycle it reads zero.
    localparam logic [c_WAIT_W-1:0] c_WAIT_POWERUP = c_WAIT_W'(POWERUP_CYC - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_RP      = c_WAIT_W'(T_RP - 2);
    localparam logic [c_WAIT_W-1:0] c_WAIT_RFC     = c_WAIT_W'(T_RFC - 2);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MRD     = c_WAIT_W'(T_MRD - 2);
    localparam logic [c_TMR_W-1:0]  c_TMR_RELOAD   = c_TMR_W'(REF_INTERVAL - 1);
    localparam logic [c_RCNT_W-1:0] c_RCNT_LAST    = c_RCNT_W'(INIT_REFRESHES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_lock_ok;
    logic [c_WAIT_W-1:0]  r_wait;
    logic                 w_wait_done;
    logic                 w_wait_load;
    logic [c_WAIT_W-1:0]  w_wait_val;
    logic [c_RCNT_W-1:0]  r_ref_cnt;
    logic                 r_ref_run;
    logic [c_TMR_W-1:0]   r_ref_tmr;
    logic                 w_ref_start;
    logic                 w_ref_expire;
    logic                 w_ack_take;
    logic                 w_ref_req_nxt;
    logic                 w_ref_late_nxt;

    logic [3:0]  r_cmd,  w_cmd_nxt;
    logic [12:0] r_addr, w_addr_nxt;
    logic [1:0]  r_ba,   w_ba_nxt;
    logic        r_cke,  w_cke_nxt;
    logic        r_own,  w_own_nxt;
    logic        r_done, w_done_nxt;
    logic        r_ref_req;
    logic        r_ref_late;

    sync_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pll_locked (pll_locked),
        .o_lock_ok    (w_lock_ok)
    );

    assign w_wait_done  = (r_wait == '0);
    assign w_ref_expire = r_ref_run && (r_ref_tmr == '0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LOCK_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_load = 1'b0;
        w_wait_val  = '0;
        w_ack_take  = 1'b0;
        case (r_state)
            ST_LOCK_WAIT: begin
                if (w_lock_ok) begin
                    w_state_nxt = ST_POWERUP;
                    w_wait_load = 1'b1;
                    w_wait_val  = c_WAIT_POWERUP;
                end
            end
            ST_POWERUP: begin
                if (w_wait_done) w_state_nxt = ST_PRECHARGE;
            end
            ST_PRECHARGE: begin
                w_state_nxt = ST_PRE_WAIT;
                w_wait_load = 1'b1;
                w_wait_val  = c_WAIT_RP;
            end
            ST_PRE_WAIT: begin
                if (w_wait_done) w_state_nxt = ST_INIT_REF;
            end
            ST_INIT_REF: begin
                w_state_nxt = ST_INIT_REF_WAIT;
                w_wait_load = 1'b1;
                w_wait_val  = c_WAIT_RFC;
            end
            ST_INIT_REF_WAIT: begin
                if (w_wait_done) begin
                    w_state_nxt = (r_ref_cnt == c_RCNT_LAST) ? ST_LOAD_MODE : ST_INIT_REF;
                end
            end
            ST_LOAD_MODE: begin
                w_state_nxt = ST_MRD_WAIT;
                w_wait_load = 1'b1;
                w_wait_val  = c_WAIT_MRD;
            end
            ST_MRD_WAIT: begin
                if (w_wait_done) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (ref_ack && r_ref_req) begin
                    w_state_nxt = ST_AUTO_REF;
                    w_ack_take  = 1'b1;
                end
            end
            ST_AUTO_REF: begin
                w_state_nxt = ST_AUTO_WAIT;
                w_wait_load = 1'b1;
                w_wait_val  = c_WAIT_RFC;
            end
            ST_AUTO_WAIT: begin
                if (w_wait_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_LOCK_WAIT;
        endcase

        // Losing lock aborts whatever is in flight and restarts from scratch.
        if (!w_lock_ok) begin
            w_state_nxt = ST_LOCK_WAIT;
            w_wait_load = 1'b0;
            w_ack_take  = 1'b0;
        end
    end

    // Registered outputs are decoded from the next state so each command
    // appears on the bus in the same cycle the FSM enters its state.
    always_comb begin
        w_cmd_nxt  = c_CMD_NOP;
        w_addr_nxt = '0;
        w_ba_nxt   = '0;
        w_cke_nxt  = 1'b1;
        w_own_nxt  = 1'b1;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            ST_LOCK_WAIT: begin
                w_cmd_nxt = c_CMD_INHIBIT;
                w_cke_nxt = 1'b0;
            end
            ST_PRECHARGE: begin
                w_cmd_nxt  = c_CMD_PRECHARGE;
                w_addr_nxt = c_ADDR_ALL_BANKS;
            end
            ST_INIT_REF:  w_cmd_nxt = c_CMD_REFRESH;
            ST_LOAD_MODE: begin
                w_cmd_nxt  = c_CMD_LOAD_MODE;
                w_addr_nxt = MODE_REG;
            end
            ST_IDLE: begin
                w_own_nxt  = 1'b0;
                w_done_nxt = 1'b1;
            end
            ST_AUTO_REF: begin
                w_cmd_nxt  = c_CMD_REFRESH;
                w_done_nxt = 1'b1;
            end
            ST_AUTO_WAIT: w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------ refresh request
    assign w_ref_start = (r_state == ST_MRD_WAIT) && (w_state_nxt == ST_IDLE);

    // An honoured ack clears the request first; a coincident expiry then
    // re-raises it, and only an unserviced expiry counts as late.
    always_comb begin
        w_ref_req_nxt  = r_ref_req;
        w_ref_late_nxt = 1'b0;
        if (w_state_nxt == ST_LOCK_WAIT) begin
            w_ref_req_nxt = 1'b0;
        end else if (w_ref_expire) begin
            w_ref_req_nxt  = 1'b1;
            w_ref_late_nxt = r_ref_req && !w_ack_take;
        end else if (w_ack_take) begin
            w_ref_req_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------ datapath regs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait     <= '0;
            r_ref_cnt  <= '0;
            r_ref_run  <= 1'b0;
            r_ref_tmr  <= '0;
            r_ref_req  <= 1'b0;
            r_ref_late <= 1'b0;
            r_cmd      <= c_CMD_INHIBIT;
            r_addr     <= '0;
            r_ba       <= '0;
            r_cke      <= 1'b0;
            r_own      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            if (w_wait_load) begin
                r_wait <= w_wait_val;
            end else if (!w_wait_done) begin
                r_wait <= r_wait - 1'b1;
            end

            if (r_state == ST_PRECHARGE) begin
                r_ref_cnt <= '0;
            end else if (r_state == ST_INIT_REF) begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end

            if (w_state_nxt == ST_LOCK_WAIT) begin
                r_ref_run <= 1'b0;
                r_ref_tmr <= '0;
            end else if (w_ref_start) begin
                r_ref_run <= 1'b1;
                r_ref_tmr <= c_TMR_RELOAD;
            end else if (w_ref_expire) begin
                r_ref_tmr <= c_TMR_RELOAD;
            end else if (r_ref_run) begin
                r_ref_tmr <= r_ref_tmr - 1'b1;
            end

            r_ref_req  <= w_ref_req_nxt;
            r_ref_late <= w_ref_late_nxt;
            r_cmd      <= w_cmd_nxt;
            r_addr     <= w_addr_nxt;
            r_ba       <= w_ba_nxt;
            r_cke      <= w_cke_nxt;
            r_own      <= w_own_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign cmd       = r_cmd;
    assign addr      = r_addr;
    assign ba        = r_ba;
    assign cke       = r_cke;
    assign cmd_own   = r_own;
    assign init_done = r_done;
    assign ref_req   = r_ref_req;
    assign ref_late  = r_ref_late;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_sdram_init_sequencer                                       |
// | Purpose  : Scoreboard bench for sdram_init_sequencer with default timing.|
// |            Expected commands and timed output samples are queued when    |
// |            stimulus is applied; a negedge monitor pops and compares.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sdram_init_sequencer;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] INH = 4'b1111;

    localparam int S_CMD = 0, S_ADDR = 1, S_BA = 2, S_CKE = 3;
    localparam int S_OWN = 4, S_DONE = 5, S_REQ = 6, S_LATE = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_locked = 1'b0;
    logic        ref_ack = 1'b0;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        cke, cmd_own, init_done, ref_req, ref_late;

    always #5 clk = ~clk;

    sdram_init_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .cmd        (cmd),
        .addr       (addr),
        .ba         (ba),
        .cke        (cke),
        .cmd_own    (cmd_own),
        .init_done  (init_done),
        .ref_req    (ref_req),
        .ref_ack    (ref_ack),
        .ref_late   (ref_late)
    );

    typedef struct { int cyc; logic [3:0] cmd; logic [12:0] addr; } cmd_exp_t;
    typedef struct { int cyc; int sig; logic [12:0] val; } chk_t;

    cmd_exp_t cmd_q[$];
    chk_t     chk_q[$];
    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int s);
        case (s)
            S_CMD:  return "cmd";
            S_ADDR: return "addr";
            S_BA:   return "ba";
            S_CKE:  return "cke";
            S_OWN:  return "cmd_own";
            S_DONE: return "init_done";
            S_REQ:  return "ref_req";
            default: return "ref_late";
        endcase
    endfunction

    function automatic logic [12:0] sig_val(input int s);
        case (s)
            S_CMD:  return {9'd0, cmd};
            S_ADDR: return addr;
            S_BA:   return {11'd0, ba};
            S_CKE:  return {12'd0, cke};
            S_OWN:  return {12'd0, cmd_own};
            S_DONE: return {12'd0, init_done};
            S_REQ:  return {12'd0, ref_req};
            default: return {12'd0, ref_late};
        endcase
    endfunction

    task automatic exp(input int c, input int s, input logic [12:0] v);
        chk_q.push_back('{c, s, v});
    endtask

    task automatic exp_cmd(input int c, input logic [3:0] cm, input logic [12:0] a);
        cmd_q.push_back('{c, cm, a});
    endtask

    task automatic exp_reset(input int c);
        exp(c, S_CMD, {9'd0, INH}); exp(c, S_ADDR, 13'd0); exp(c, S_BA, 13'd0);
        exp(c, S_CKE, 13'd0);       exp(c, S_OWN, 13'd1);  exp(c, S_DONE, 13'd0);
        exp(c, S_REQ, 13'd0);       exp(c, S_LATE, 13'd0);
    endtask

    // Full init sequence given the cycle E in which POWERUP is entered.
    task automatic expect_init(input int e, output int i_done);
        int p;
        p = e + 14300;
        exp(e - 1, S_CKE, 13'd0);
        exp(e, S_CKE, 13'd1);
        exp(e, S_CMD, {9'd0, NOP});
        exp(e, S_OWN, 13'd1);
        exp_cmd(p, PRE, 13'h0400);
        for (int k = 0; k < 8; k++) exp_cmd(p + 3 + 10 * k, REF, 13'h0000);
        exp_cmd(p + 83, LMR, 13'h0030);
        exp(p + 84, S_DONE, 13'd0);
        exp(p + 84, S_OWN, 13'd1);
        exp(p + 85, S_DONE, 13'd1);
        exp(p + 85, S_OWN, 13'd0);
        exp(p + 85, S_CKE, 13'd1);
        i_done = p + 85;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (cmd !== NOP && cmd !== INH) begin
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected cycle %0d: got cmd=%b addr=%h, required no command", cyc, cmd, addr);
                end else begin
                    cmd_exp_t e;
                    e = cmd_q.pop_front();
                    if (e.cyc != cyc || cmd !== e.cmd || addr !== e.addr || ba !== 2'b00) begin
                        errors++;
                        $display("FAIL cmd_seq: got cmd=%b addr=%h ba=%0d at cycle %0d, required cmd=%b addr=%h ba=0 at cycle %0d",
                                 cmd, addr, ba, cyc, e.cmd, e.addr, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (addr !== 13'd0 || ba !== 2'd0) begin
                    errors++;
                    $display("FAIL addr_quiet cycle %0d: got addr=%h ba=%0d, required 0", cyc, addr, ba);
                end
            end
            for (int i = chk_q.size() - 1; i >= 0; i--) begin
                if (chk_q[i].cyc <= cyc) begin
                    checks++;
                    if (chk_q[i].cyc != cyc || sig_val(chk_q[i].sig) !== chk_q[i].val) begin
                        errors++;
                        $display("FAIL %s cycle %0d: got %0h, required %0h (due cycle %0d)",
                                 sig_name(chk_q[i].sig), cyc, sig_val(chk_q[i].sig), chk_q[i].val, chk_q[i].cyc);
                    end
                    chk_q.delete(i);
                end
            end
        end
    end

    // ----------------------------------------------------------- stimulus
    initial begin
        int l, i1, n, m, r, l2, e2, p2, d, i3;

        exp_reset(2);
        wait_until(4);
        rst_n = 1'b1;
        exp(8, S_CMD, {9'd0, INH});
        exp(8, S_CKE, 13'd0);

        // Run 1: clean lock, full init, refresh handshake
        wait_until(10);
        l = cyc;
        pll_locked = 1'b1;
        expect_init(l + 18, i1);
        exp(i1 + 1116, S_REQ, 13'd0);
        exp(i1 + 1117, S_REQ, 13'd1);
        exp(i1 + 2233, S_LATE, 13'd0);
        exp(i1 + 2234, S_LATE, 13'd1);
        exp(i1 + 2234, S_REQ, 13'd1);
        exp(i1 + 2235, S_LATE, 13'd0);
        exp(i1 + 2235, S_REQ, 13'd1);

        // ack with no request pending is ignored
        wait_until(i1 + 100);
        ref_ack = 1'b1;
        exp(i1 + 101, S_OWN, 13'd0);
        exp(i1 + 101, S_REQ, 13'd0);
        wait_until(i1 + 101);
        ref_ack = 1'b0;

        // ack coincident with the third expiry
        n = i1 + 3350;
        exp_cmd(n + 1, REF, 13'h0000);
        exp(n + 1, S_REQ, 13'd1);
        exp(n + 1, S_OWN, 13'd1);
        exp(n + 1, S_DONE, 13'd1);
        exp(n + 6, S_REQ, 13'd1);
        exp(n + 10, S_OWN, 13'd1);
        exp(n + 11, S_OWN, 13'd0);
        wait_until(n);
        ref_ack = 1'b1;
        wait_until(n + 1);
        ref_ack = 1'b0;
        // ack during AUTO_WAIT is ignored
        wait_until(n + 5);
        ref_ack = 1'b1;
        wait_until(n + 6);
        ref_ack = 1'b0;

        // normal ack from IDLE
        m = n + 12;
        exp_cmd(m + 1, REF, 13'h0000);
        exp(m + 1, S_REQ, 13'd0);
        exp(m + 1, S_OWN, 13'd1);
        wait_until(m);
        ref_ack = 1'b1;
        wait_until(m + 1);
        ref_ack = 1'b0;

        // reset in the middle of AUTO_WAIT
        wait_until(m + 4);
        rst_n = 1'b0;
        pll_locked = 1'b0;
        exp_reset(m + 5);
        wait_until(m + 8);
        r = cyc;
        rst_n = 1'b1;

        // Run 2: lock glitch at filter count 10, then lock loss in INIT_REF_WAIT
        wait_until(r + 5);
        l2 = cyc;
        pll_locked = 1'b1;
        e2 = l2 + 29;
        p2 = e2 + 14300;
        exp(l2 + 18, S_CKE, 13'd0);
        exp(e2 - 1, S_CKE, 13'd0);
        exp(e2, S_CKE, 13'd1);
        exp_cmd(p2, PRE, 13'h0400);
        exp_cmd(p2 + 3, REF, 13'h0000);
        wait_until(l2 + 10);
        pll_locked = 1'b0;
        wait_until(l2 + 11);
        pll_locked = 1'b1;

        d = p2 + 5;
        wait_until(d);
        pll_locked = 1'b0;
        exp(d + 2, S_CKE, 13'd1);
        exp(d + 3, S_CKE, 13'd0);
        exp(d + 3, S_CMD, {9'd0, INH});
        exp(d + 3, S_OWN, 13'd1);
        exp(d + 3, S_DONE, 13'd0);

        // Run 3: relock, full sequence repeats
        wait_until(d + 20);
        pll_locked = 1'b1;
        expect_init(cyc + 18, i3);
        wait_until(i3 + 10);

        checks++;
        if (cmd_q.size() != 0 || chk_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d commands and %0d samples pending, required 0", cmd_q.size(), chk_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
